// File: rtl/fetch_queue.sv
// Instruction prefetch queue between instruction memory and the IF/ID register.
// Issues sequential fetches on credit, buffers responses, and discards in-flight data after a redirect.
module fetch_queue #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            stall_d,
    input  logic            flush,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            valid_f,
    output logic [XLEN-1:0] instr_f,
    output logic [XLEN-1:0] pc_f,
    output logic [XLEN-1:0] pcplus4_f
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned SW = CW + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          head;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] resp_pc;
    logic [CW-1:0]   count;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop_cnt;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            issue;
    logic            push;
    logic            pop;
    logic            drop;

    // Credit check counts in-flight requests so a response always has a free slot.
    always_comb begin
        imem_req  = 1'b0;
        if (reset_n && !flush && ((SW'(count) + SW'(outstanding)) < SW'(DEPTH)))
            imem_req = 1'b1;
        imem_addr = fetch_pc;
        issue     = imem_req && imem_gnt;
        drop      = imem_rvalid && (drop_cnt != '0);
        push      = imem_rvalid && !flush && (drop_cnt == '0);
        valid_f   = (count != '0);
        pop       = valid_f && !stall_d && !flush;
        head      = mem[rd_ptr];
        instr_f   = valid_f ? head.instr : '0;
        pc_f      = valid_f ? head.pc : resp_pc;
        pcplus4_f = pc_f + XLEN'(4);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else if (flush) begin
            // Everything still owed by memory becomes a response to throw away.
            fetch_pc    <= redirect_pc;
            resp_pc     <= redirect_pc;
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            outstanding <= outstanding - CW'(imem_rvalid);
            drop_cnt    <= outstanding - CW'(imem_rvalid);
        end else begin
            if (issue)
                fetch_pc <= fetch_pc + XLEN'(4);
            outstanding <= outstanding + CW'(issue) - CW'(imem_rvalid);
            if (drop)
                drop_cnt <= drop_cnt - CW'(1);
            if (push) begin
                resp_pc <= resp_pc + XLEN'(4);
                wr_ptr  <= wr_ptr + PW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= '{pc: resp_pc, instr: imem_rdata};
    end

`ifndef SYNTHESIS
    a_no_push_full: assert property (@(posedge clk) disable iff (!reset_n)
        !(push && (count == CW'(DEPTH))));
    a_no_stray_rvalid: assert property (@(posedge clk) disable iff (!reset_n)
        !(imem_rvalid && (outstanding == '0)));
    a_drop_bounded: assert property (@(posedge clk) disable iff (!reset_n)
        drop_cnt <= outstanding);
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue; memory returns ~addr in request order, one cycle after grant unless held.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        stall_d;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        valid_f;
    logic [31:0] instr_f;
    logic [31:0] pc_f;
    logic [31:0] pcplus4_f;

    int          n_cmp   = 0;
    int          n_fail  = 0;
    int          n_grant = 0;
    bit          hold;
    logic [31:0] pending[$];

    fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset_n(reset_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .stall_d(stall_d), .flush(flush), .redirect_pc(redirect_pc),
        .valid_f(valid_f), .instr_f(instr_f), .pc_f(pc_f), .pcplus4_f(pcplus4_f)
    );

    always #5 clk = ~clk;

    task automatic drive_mem();
        imem_rvalid = (pending.size() > 0) && !hold;
        imem_rdata  = 32'h0;
        if (imem_rvalid)
            imem_rdata = ~pending[0];
    endtask

    // One clock: capture handshake before the edge, update the memory model after it.
    task automatic cyc();
        logic        hs;
        logic        rv;
        logic [31:0] a;
        #1;
        hs = imem_req && imem_gnt;
        rv = imem_rvalid;
        a  = imem_addr;
        @(posedge clk);
        @(negedge clk);
        if (rv)
            void'(pending.pop_front());
        if (hs) begin
            pending.push_back(a);
            n_grant++;
        end
        drive_mem();
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        flush       = 1'b0;
        stall_d     = 1'b0;
        imem_gnt    = 1'b1;
        redirect_pc = 32'h0;
        hold        = 1'b0;
        pending.delete();
        drive_mem();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        if (imem_req !== 1'b0) begin $display("FAIL rst_req: got %b want 0", imem_req); n_fail++; end
        n_cmp++;
        if (valid_f !== 1'b0) begin $display("FAIL rst_valid: got %b want 0", valid_f); n_fail++; end
        n_cmp++;
        if (imem_addr !== 32'h0) begin $display("FAIL rst_addr: got %h want 0", imem_addr); n_fail++; end
        n_cmp++;
        if (pc_f !== 32'h0) begin $display("FAIL rst_pc: got %h want 0", pc_f); n_fail++; end
        n_cmp++;
        if (pcplus4_f !== 32'h4) begin $display("FAIL rst_pcplus4: got %h want 4", pcplus4_f); n_fail++; end
        n_cmp++;
        if (instr_f !== 32'h0) begin $display("FAIL rst_instr: got %h want 0", instr_f); n_fail++; end
        n_cmp++;
    endtask

    task automatic test_stream();
        logic [31:0] exp;
        do_reset();
        #1;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            $display("FAIL stream_first_req: got req=%b addr=%h want req=1 addr=0", imem_req, imem_addr); n_fail++;
        end
        n_cmp++;
        if (valid_f !== 1'b0) begin $display("FAIL stream_c0_valid: got %b want 0", valid_f); n_fail++; end
        n_cmp++;
        cyc();
        if (valid_f !== 1'b0) begin $display("FAIL stream_c1_valid: got %b want 0", valid_f); n_fail++; end
        n_cmp++;
        cyc();
        for (int k = 0; k < 6; k++) begin
            exp = 32'(4 * k);
            if (valid_f !== 1'b1 || pc_f !== exp || instr_f !== ~exp || pcplus4_f !== exp + 32'h4) begin
                $display("FAIL stream_pop%0d: got v=%b pc=%h instr=%h pc4=%h want v=1 pc=%h instr=%h pc4=%h",
                         k, valid_f, pc_f, instr_f, pcplus4_f, exp, ~exp, exp + 32'h4);
                n_fail++;
            end
            n_cmp++;
            cyc();
        end
    endtask

    task automatic test_stall();
        int          g0;
        logic [31:0] exp;
        do_reset();
        stall_d = 1'b1;
        g0 = n_grant;
        repeat (10) cyc();
        if (n_grant - g0 != 4) begin $display("FAIL stall_grants: got %0d want 4", n_grant - g0); n_fail++; end
        n_cmp++;
        #1;
        if (imem_req !== 1'b0) begin $display("FAIL stall_req_off: got %b want 0", imem_req); n_fail++; end
        n_cmp++;
        stall_d = 1'b0;
        for (int k = 0; k < 5; k++) begin
            exp = 32'(4 * k);
            if (valid_f !== 1'b1 || pc_f !== exp || instr_f !== ~exp) begin
                $display("FAIL stall_drain%0d: got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h",
                         k, valid_f, pc_f, instr_f, exp, ~exp);
                n_fail++;
            end
            n_cmp++;
            cyc();
        end
    endtask

    task automatic test_stall_hold();
        do_reset();
        stall_d = 1'b1;
        cyc();
        imem_gnt = 1'b0;
        repeat (6) cyc();
        if (valid_f !== 1'b1 || pc_f !== 32'h0 || instr_f !== 32'hFFFF_FFFF) begin
            $display("FAIL hold_retained: got v=%b pc=%h instr=%h want v=1 pc=0 instr=ffffffff", valid_f, pc_f, instr_f);
            n_fail++;
        end
        n_cmp++;
        stall_d = 1'b0;
        cyc();
        if (valid_f !== 1'b0) begin $display("FAIL hold_popped: got %b want 0", valid_f); n_fail++; end
        n_cmp++;
    endtask

    task automatic test_flush();
        do_reset();
        stall_d = 1'b1;
        hold    = 1'b1;
        drive_mem();
        repeat (4) cyc();
        hold = 1'b0;
        drive_mem();
        repeat (2) cyc();
        hold = 1'b1;
        drive_mem();
        if (valid_f !== 1'b1 || pc_f !== 32'h0) begin
            $display("FAIL flush_setup: got v=%b pc=%h want v=1 pc=0", valid_f, pc_f); n_fail++;
        end
        n_cmp++;
        flush       = 1'b1;
        redirect_pc = 32'h100;
        #1;
        if (imem_req !== 1'b0) begin $display("FAIL flush_req_off: got %b want 0", imem_req); n_fail++; end
        n_cmp++;
        cyc();
        flush   = 1'b0;
        stall_d = 1'b0;
        hold    = 1'b0;
        drive_mem();
        #1;
        if (valid_f !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            $display("FAIL flush_after: got v=%b req=%b addr=%h want v=0 req=1 addr=100", valid_f, imem_req, imem_addr);
            n_fail++;
        end
        n_cmp++;
        for (int k = 0; k < 2; k++) begin
            cyc();
            if (valid_f !== 1'b0) begin $display("FAIL flush_drop%0d: got v=%b pc=%h want v=0", k, valid_f, pc_f); n_fail++; end
            n_cmp++;
        end
        cyc();
        if (valid_f !== 1'b1 || pc_f !== 32'h100 || instr_f !== ~32'h100) begin
            $display("FAIL flush_first: got v=%b pc=%h instr=%h want v=1 pc=100 instr=%h", valid_f, pc_f, instr_f, ~32'h100);
            n_fail++;
        end
        n_cmp++;
        cyc();
        if (valid_f !== 1'b1 || pc_f !== 32'h104) begin
            $display("FAIL flush_second: got v=%b pc=%h want v=1 pc=104", valid_f, pc_f); n_fail++;
        end
        n_cmp++;
    endtask

    task automatic test_flush_rvalid();
        do_reset();
        stall_d = 1'b1;
        hold    = 1'b1;
        drive_mem();
        cyc();
        imem_gnt = 1'b0;
        hold     = 1'b0;
        drive_mem();
        flush       = 1'b1;
        redirect_pc = 32'h200;
        cyc();
        flush    = 1'b0;
        stall_d  = 1'b0;
        imem_gnt = 1'b1;
        #1;
        if (valid_f !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
            $display("FAIL fr_after: got v=%b req=%b addr=%h want v=0 req=1 addr=200", valid_f, imem_req, imem_addr);
            n_fail++;
        end
        n_cmp++;
        cyc();
        if (valid_f !== 1'b0) begin $display("FAIL fr_stale: got v=%b pc=%h want v=0", valid_f, pc_f); n_fail++; end
        n_cmp++;
        cyc();
        if (valid_f !== 1'b1 || pc_f !== 32'h200 || instr_f !== ~32'h200) begin
            $display("FAIL fr_first: got v=%b pc=%h instr=%h want v=1 pc=200 instr=%h", valid_f, pc_f, instr_f, ~32'h200);
            n_fail++;
        end
        n_cmp++;
    endtask

    task automatic test_wrap();
        do_reset();
        flush       = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        cyc();
        flush = 1'b0;
        #1;
        if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
            $display("FAIL wrap_addr0: got req=%b addr=%h want req=1 addr=fffffffc", imem_req, imem_addr); n_fail++;
        end
        n_cmp++;
        cyc();
        if (imem_addr !== 32'h0) begin $display("FAIL wrap_addr1: got %h want 0", imem_addr); n_fail++; end
        n_cmp++;
        cyc();
        if (valid_f !== 1'b1 || pc_f !== 32'hFFFF_FFFC || pcplus4_f !== 32'h0 || instr_f !== 32'h3) begin
            $display("FAIL wrap_head: got v=%b pc=%h pc4=%h instr=%h want v=1 pc=fffffffc pc4=0 instr=3",
                     valid_f, pc_f, pcplus4_f, instr_f);
            n_fail++;
        end
        n_cmp++;
        cyc();
        if (valid_f !== 1'b1 || pc_f !== 32'h0 || pcplus4_f !== 32'h4) begin
            $display("FAIL wrap_next: got v=%b pc=%h pc4=%h want v=1 pc=0 pc4=4", valid_f, pc_f, pcplus4_f); n_fail++;
        end
        n_cmp++;
    endtask

    task automatic test_async_reset();
        do_reset();
        stall_d = 1'b1;
        repeat (8) cyc();
        if (valid_f !== 1'b1 || imem_req !== 1'b0) begin
            $display("FAIL ar_full: got v=%b req=%b want v=1 req=0", valid_f, imem_req); n_fail++;
        end
        n_cmp++;
        #2;
        reset_n = 1'b0;
        #1;
        if (valid_f !== 1'b0 || imem_req !== 1'b0) begin
            $display("FAIL ar_immediate: got v=%b req=%b want v=0 req=0", valid_f, imem_req); n_fail++;
        end
        n_cmp++;
        pending.delete();
        hold    = 1'b0;
        stall_d = 1'b0;
        drive_mem();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1;
        if (valid_f !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            $display("FAIL ar_restart: got v=%b req=%b addr=%h want v=0 req=1 addr=0", valid_f, imem_req, imem_addr);
            n_fail++;
        end
        n_cmp++;
        cyc();
        cyc();
        if (valid_f !== 1'b1 || pc_f !== 32'h0 || instr_f !== 32'hFFFF_FFFF) begin
            $display("FAIL ar_first: got v=%b pc=%h instr=%h want v=1 pc=0 instr=ffffffff", valid_f, pc_f, instr_f);
            n_fail++;
        end
        n_cmp++;
    endtask

    initial begin
        reset_n     = 1'b0;
        imem_gnt    = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        stall_d     = 1'b0;
        flush       = 1'b0;
        redirect_pc = 32'h0;
        hold        = 1'b0;
        test_reset();
        @(negedge clk);
        test_stream();
        test_stall();
        test_stall_hold();
        test_flush();
        test_flush_rvalid();
        test_wrap();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run still active at %0t, want finished", $time);
        $fatal(1);
    end

endmodule
